// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel-rate divider, horizontal/vertical
// counters, sync/blank decode and a per-frame strobe for frame-rate logic.
module vga_timing_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pix_tick,
    output logic       vga_clk,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       sync_n,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2);
    localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]    H_VIS     = 10'(H_ACTIVE);
    localparam logic [9:0]    V_VIS     = 10'(V_ACTIVE);

    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;
    logic [9:0]    hcnt;
    logic [9:0]    vcnt;
    logic          h_last;
    logic          v_last;

    // Next divider value, wrapping after the last clk of a pixel period
    always_comb begin
        div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
    end

    // Pixel divider; vga_clk is registered from the next divider value so it
    // tracks (div >= CLK_DIV/2) exactly while staying glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div     <= '0;
            vga_clk <= 1'b0;
        end else if (en) begin
            div     <= div_nxt;
            vga_clk <= (div_nxt >= DIV_HALF);
        end
    end

    assign pix_tick = en && (div == DIV_LAST);
    assign h_last   = (hcnt == H_LAST);
    assign v_last   = (vcnt == V_LAST);

    // Horizontal and vertical raster counters, stepped once per pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_tick) begin
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Sync/blank decodes aligned with x/y in the same cycle
    always_comb begin
        hsync       = !((hcnt >= HS_START) && (hcnt < HS_END));
        vsync       = !((vcnt >= VS_START) && (vcnt < VS_END));
        blank_n     = (hcnt < H_VIS) && (vcnt < V_VIS);
        frame_start = pix_tick && h_last && v_last;
    end

    assign x      = hcnt;
    assign y      = vcnt;
    assign sync_n = 1'b0;

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Generates the VGA raster timing that sequences the pixel datapath (video generator, rectangle generator).
- Divides the system clock down to a pixel rate and runs horizontal and vertical counters.
- Drives x/y pixel coordinates to the video generator, and hsync/vsync/blank_n/sync_n/vga_clk to the DAC/connector.
- Provides a one-cycle frame_start strobe so frame-rate logic (e.g. object motion) can update between frames.

Parameters:
- CLK_DIV, 2, system clocks per pixel; legal values ≥2, even.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync pulse width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync pulse width, in lines.
- V_BP, 33, vertical back porch, in lines.

Ports:
- clk  in  1  system clock, 50 MHz nominal.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; when low, all counters hold.
- x  out  10  current pixel column (raw horizontal count, 0..H_TOTAL-1).
- y  out  10  current line (raw vertical count, 0..V_TOTAL-1).
- pix_tick  out  1  one-clk strobe marking the last clk of each pixel period.
- vga_clk  out  1  pixel clock to the DAC.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- blank_n  out  1  high inside the visible area.
- sync_n  out  1  composite sync to the DAC; tied to 0.
- frame_start  out  1  one-clk strobe on the last clk of the frame.

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024 so counters fit in 10 bits.
- Reset (async, rst_n=0): div=0, hcnt=0, vcnt=0. Outputs take their reset values immediately, with no clock edge: x=0, y=0, pix_tick=0, vga_clk=0, hsync=1, vsync=1, blank_n=1, frame_start=0.
- Divider: div counts 0..CLK_DIV-1 on each clk while en=1, then wraps to 0. While en=0, div holds.
- pix_tick = en && (div == CLK_DIV-1).
- vga_clk = (div ≥ CLK_DIV/2). It is registered-derived and glitch-free. Counters change on the clk edge where div wraps, which is the vga_clk falling edge; the monitor samples stable data on the rising edge.
- Horizontal: on pix_tick, hcnt increments. At hcnt = H_TOTAL-1, hcnt wraps to 0 and the vertical step occurs.
- Vertical: on that same tick, vcnt increments. At vcnt = V_TOTAL-1, vcnt wraps to 0.
- x = hcnt and y = vcnt, taken straight from registers, so latency from counter update is 0.
- Sync and blank are combinational decodes of the registered hcnt/vcnt, aligned with x/y in the same cycle:
  - hsync = 0 iff H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync = 0 iff V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC (490..491).
  - blank_n = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- frame_start = pix_tick && hcnt==H_TOTAL-1 && vcnt==V_TOTAL-1. It is high for exactly one clk per frame; on the next clk, x=0 and y=0.
- en deasserted mid-pixel: div, hcnt, vcnt and vga_clk freeze, and pix_tick and frame_start stay 0. Counting resumes from the held div value, so no pixel is skipped or repeated.
- Reset asserted mid-frame: immediate return to the reset state. After release, the first pix_tick occurs CLK_DIV clks after the first enabled edge.

Test Plan:
1. Release reset with en=1, CLK_DIV=2 -> x=0, y=0, hsync=1, vsync=1, blank_n=1, vga_clk=0; vga_clk=1 after 1 clk; x=1 after 2 clks.
2. Run one line -> blank_n falls at x=640; hsync low for x=656..751 (192 clks); x wraps 799→0 as y goes 0→1; line period 1600 clks.
3. Run two frames -> vsync low only for y=490..491; y wraps 524→0; frame_start pulses exactly once per 840000 clks, each pulse one clk wide with x=799, y=524.
4. Drop en at x=100 (div=0) for 10 clks -> x stays 100, vga_clk holds, no pix_tick; after en returns, x=101 two clks later.
5. Assert rst_n=0 asynchronously at x=300, y=200 between clk edges -> x=0, y=0, hsync=1, vsync=1 immediately, with no clk edge.
6. Rebuild with CLK_DIV=4 -> x advances every 4 clks; vga_clk low 2 clks, high 2 clks; pix_tick one clk in four.
